// File: rtl/mem_writeback.sv
// mem_writeback: memory-access and writeback stage.
//
// Accepts one operation at a time from the decode/execute stage, performs a
// data-memory load or store over a req/ack handshake (with a bounded wait),
// and owns the 32x32 architectural register file. Register 0 is hardwired
// to zero.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   upstream handshake; in_ready is high only in IDLE
//   in_result             ALU result or store data
//   in_reg_write_enable   write in_register at writeback (ALU ops only)
//   in_mem_write_enable   store in_result to in_mem_address (wins over load)
//   in_mem_read_enable    load from in_mem_address into in_register
//   in_register           destination register
//   in_mem_address        data-memory byte address
//   mem_req/mem_we/mem_addr/mem_wdata   memory request, held until ack/timeout
//   mem_ack/mem_rdata     one-cycle completion with load data
//   rs1_addr/rs1_data, rs2_addr/rs2_data  combinational read ports with
//                         bypass of the value being written in WB
//   wb_valid/wb_register/wb_data  one-cycle writeback pulse
//   bus_error             one-cycle pulse after a memory timeout
module mem_writeback #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_reg_write_enable,
  input  logic        in_mem_write_enable,
  input  logic        in_mem_read_enable,
  input  logic [4:0]  in_register,
  input  logic [31:0] in_mem_address,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        wb_valid,
  output logic [4:0]  wb_register,
  output logic [31:0] wb_data,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  // Last wait-counter value before the access is abandoned; the counter is 0
  // in the first MEM cycle, so mem_req stays high exactly TIMEOUT cycles.
  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [4:0]  dest;
  logic [31:0] regs [32];

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      dest        <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_register <= '0;
      wb_data     <= '0;
      bus_error   <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      wb_valid  <= 1'b0;
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mem_addr  <= in_mem_address;
            mem_wdata <= in_result;
            // A store wins when both memory enables are set.
            mem_we    <= in_mem_write_enable;
            dest      <= in_register;
            wait_cnt  <= '0;
            if (in_mem_write_enable || in_mem_read_enable) begin
              mem_req <= 1'b1;
              state   <= MEM;
            end else if (in_reg_write_enable) begin
              wb_register <= in_register;
              wb_data     <= in_result;
              wb_valid    <= 1'b1;
              state       <= WB;
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= IDLE;
            end else begin
              // Loads always write back, independent of in_reg_write_enable.
              wb_register <= dest;
              wb_data     <= mem_rdata;
              wb_valid    <= 1'b1;
              state       <= WB;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        WB: begin
          if (wb_register != 5'd0) regs[wb_register] <= wb_data;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // During WB the file is not yet updated, so forward the pending value.
  function automatic logic [31:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0)
      return 32'd0;
    else if (state == WB && addr == wb_register)
      return wb_data;
    else
      return regs[addr];
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);

endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_reg_write_enable;
  logic        in_mem_write_enable;
  logic        in_mem_read_enable;
  logic [4:0]  in_register;
  logic [31:0] in_mem_address;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_register;
  logic [31:0] wb_data;
  logic        bus_error;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;

  wb_t exp_q[$];
  int  compared = 0;
  int  mismatched = 0;

  mem_writeback #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result),
    .in_reg_write_enable(in_reg_write_enable),
    .in_mem_write_enable(in_mem_write_enable),
    .in_mem_read_enable(in_mem_read_enable),
    .in_register(in_register), .in_mem_address(in_mem_address),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_register(wb_register), .wb_data(wb_data),
    .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation at a negedge; it is accepted at the next posedge.
  task automatic issue(input logic regwe, input logic memwe, input logic memre,
                       input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] addr);
    in_valid            = 1'b1;
    in_reg_write_enable = regwe;
    in_mem_write_enable = memwe;
    in_mem_read_enable  = memre;
    in_register         = rd;
    in_result           = res;
    in_mem_address      = addr;
    @(posedge clk);
    #1;
    in_valid            = 1'b0;
    in_reg_write_enable = 1'b0;
    in_mem_write_enable = 1'b0;
    in_mem_read_enable  = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rs1_addr = 5'd7;
    #1;
    compared++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || wb_valid !== 1'b0 ||
        bus_error !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 ||
        wb_register !== 5'd0 || wb_data !== 32'd0 || rs1_data !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_state: rdy=%b req=%b we=%b wbv=%b berr=%b addr=%h wdata=%h wbr=%0d wbd=%h rs1=%h, required rdy=1 and all others 0",
               in_ready, mem_req, mem_we, wb_valid, bus_error, mem_addr, mem_wdata, wb_register, wb_data, rs1_data);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_alu;
    wb_t e;
    @(negedge clk);
    rs1_addr = 5'd7;
    exp_q.push_back('{r: 5'd7, d: 32'h0000_00A5});
    issue(1'b1, 1'b0, 1'b0, 5'd7, 32'h0000_00A5, 32'h0);
    @(negedge clk);
    compared++;
    if (wb_valid !== 1'b1 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL alu_wb_cycle: wb_valid=%b in_ready=%b, required 1/0", wb_valid, in_ready);
    end
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL alu_sb_empty: no expected entry, required one");
    end else begin
      e = exp_q.pop_front();
      compared++;
      if (wb_register !== e.r || wb_data !== e.d) begin
        mismatched++;
        $display("FAIL alu_wb: reg=%0d data=%h, required reg=%0d data=%h", wb_register, wb_data, e.r, e.d);
      end
    end
    compared++;
    if (rs1_data !== 32'h0000_00A5) begin
      mismatched++;
      $display("FAIL alu_bypass: rs1_data=%h, required 000000a5", rs1_data);
    end
    @(negedge clk);
    compared++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1 || rs1_data !== 32'h0000_00A5) begin
      mismatched++;
      $display("FAIL alu_after: wb_valid=%b in_ready=%b rs1=%h, required 0/1/000000a5", wb_valid, in_ready, rs1_data);
    end
    $display("alu op reg7=0xA5 done");
  endtask

  task automatic test_store;
    int  high = 0;
    bit  seen_wb = 0;
    bit  unstable = 0;
    @(negedge clk);
    // All enables set: behaves as a pure store, no writeback.
    issue(1'b1, 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'h0000_0100);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_valid) seen_wb = 1;
      if (!mem_req) break;
      high++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || in_ready !== 1'b0)
        unstable = 1;
      mem_ack = (high == 4);
    end
    mem_ack = 1'b0;
    compared++;
    if (high != 4) begin
      mismatched++;
      $display("FAIL store_req_len: mem_req high %0d cycles, required 4", high);
    end
    compared++;
    if (unstable) begin
      mismatched++;
      $display("FAIL store_hold: we/addr/wdata/in_ready not held during MEM, required 1/100/deadbeef/0");
    end
    compared++;
    if (seen_wb || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL store_end: wb seen=%0d in_ready=%b, required 0/1", seen_wb, in_ready);
    end
    $display("store 0xDEADBEEF to 0x100 with 3 waits done");
  endtask

  task automatic test_load;
    wb_t e;
    @(negedge clk);
    rs1_addr = 5'd12;
    exp_q.push_back('{r: 5'd12, d: 32'h1234_5678});
    issue(1'b0, 1'b0, 1'b1, 5'd12, 32'h0, 32'h0000_0200);
    @(negedge clk);
    compared++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin
      mismatched++;
      $display("FAIL load_req: req=%b we=%b addr=%h, required 1/0/00000200", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    compared++;
    if (wb_valid !== 1'b1 || mem_req !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL load_wb_cycle: wbv=%b req=%b rdy=%b, required 1/0/0", wb_valid, mem_req, in_ready);
    end
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL load_sb_empty: no expected entry, required one");
    end else begin
      e = exp_q.pop_front();
      compared++;
      if (wb_register !== e.r || wb_data !== e.d) begin
        mismatched++;
        $display("FAIL load_wb: reg=%0d data=%h, required reg=%0d data=%h", wb_register, wb_data, e.r, e.d);
      end
    end
    @(negedge clk);
    compared++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1 || rs1_data !== 32'h1234_5678) begin
      mismatched++;
      $display("FAIL load_after: wbv=%b rdy=%b rs1=%h, required 0/1/12345678", wb_valid, in_ready, rs1_data);
    end
    $display("load 0x12345678 into reg12 done");
  endtask

  task automatic test_reg0;
    wb_t e;
    @(negedge clk);
    rs2_addr = 5'd0;
    exp_q.push_back('{r: 5'd0, d: 32'hFFFF_FFFF});
    issue(1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    compared++;
    if (wb_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL reg0_wbv: wb_valid=%b, required 1", wb_valid);
    end
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL reg0_sb_empty: no expected entry, required one");
    end else begin
      e = exp_q.pop_front();
      compared++;
      if (wb_register !== e.r || wb_data !== e.d) begin
        mismatched++;
        $display("FAIL reg0_wb: reg=%0d data=%h, required reg=%0d data=%h", wb_register, wb_data, e.r, e.d);
      end
    end
    compared++;
    if (rs2_data !== 32'd0) begin
      mismatched++;
      $display("FAIL reg0_bypass: rs2_data=%h during WB, required 0", rs2_data);
    end
    @(negedge clk);
    compared++;
    if (rs2_data !== 32'd0) begin
      mismatched++;
      $display("FAIL reg0_read: rs2_data=%h, required 0", rs2_data);
    end
    $display("write to reg0 done");
  endtask

  task automatic test_timeout;
    int high = 0;
    @(negedge clk);
    rs1_addr = 5'd12;
    issue(1'b1, 1'b0, 1'b1, 5'd12, 32'h0, 32'h0000_0300);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      high++;
      compared++;
      if (bus_error !== 1'b0 || wb_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL timeout_early: bus_error=%b wb_valid=%b in MEM cycle %0d, required 0/0", bus_error, wb_valid, high);
      end
    end
    compared++;
    if (high != 15) begin
      mismatched++;
      $display("FAIL timeout_len: mem_req high %0d cycles, required 15", high);
    end
    compared++;
    if (bus_error !== 1'b1 || in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_pulse: bus_error=%b rdy=%b wbv=%b, required 1/1/0", bus_error, in_ready, wb_valid);
    end
    @(negedge clk);
    compared++;
    if (bus_error !== 1'b0 || wb_valid !== 1'b0 || rs1_data !== 32'h1234_5678) begin
      mismatched++;
      $display("FAIL timeout_after: bus_error=%b wbv=%b rs1=%h, required 0/0/12345678", bus_error, wb_valid, rs1_data);
    end
    $display("load timeout after %0d cycles done", high);
  endtask

  task automatic test_back_to_back;
    wb_t e;
    @(negedge clk);
    rs1_addr = 5'd3;
    rs2_addr = 5'd4;
    exp_q.push_back('{r: 5'd3, d: 32'h0000_0033});
    exp_q.push_back('{r: 5'd4, d: 32'h0000_0044});
    issue(1'b1, 1'b0, 1'b0, 5'd3, 32'h33, 32'h0);
    // Keep the second op presented; it must wait out the WB cycle.
    in_valid = 1'b1;
    in_reg_write_enable = 1'b1;
    in_register = 5'd4;
    in_result = 32'h44;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        in_reg_write_enable = 1'b0;
      end
      compared++;
      if (wb_valid !== 1'b1 || in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_wb%0d: wbv=%b rdy=%b, required 1/0", k, wb_valid, in_ready);
      end
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL b2b_sb_empty: no expected entry, required one");
      end else begin
        e = exp_q.pop_front();
        compared++;
        if (wb_register !== e.r || wb_data !== e.d) begin
          mismatched++;
          $display("FAIL b2b_data%0d: reg=%0d data=%h, required reg=%0d data=%h", k, wb_register, wb_data, e.r, e.d);
        end
      end
      @(negedge clk);
      compared++;
      if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_idle%0d: rdy=%b wbv=%b, required 1/0", k, in_ready, wb_valid);
      end
    end
    @(negedge clk);
    compared++;
    if (rs1_data !== 32'h33 || rs2_data !== 32'h44) begin
      mismatched++;
      $display("FAIL b2b_regs: rs1=%h rs2=%h, required 00000033/00000044", rs1_data, rs2_data);
    end
    $display("back-to-back alu ops done");
  endtask

  task automatic test_reset_mid;
    bit seen_wb = 0;
    @(negedge clk);
    issue(1'b0, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0000_0400);
    repeat (2) @(negedge clk);
    compared++;
    if (mem_req !== 1'b1) begin
      mismatched++;
      $display("FAIL rmid_req: mem_req=%b before reset, required 1", mem_req);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL rmid_async: mem_req=%b right after reset, required 0", mem_req);
    end
    @(negedge clk);
    rs1_addr = 5'd12;
    rs2_addr = 5'd7;
    #1;
    compared++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 ||
        wb_register !== 5'd0 || wb_data !== 32'd0 || bus_error !== 1'b0 || wb_valid !== 1'b0 ||
        rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      mismatched++;
      $display("FAIL rmid_state: rdy=%b we=%b addr=%h wdata=%h wbr=%0d wbd=%h berr=%b wbv=%b rs1=%h rs2=%h, required rdy=1 others 0",
               in_ready, mem_we, mem_addr, mem_wdata, wb_register, wb_data, bus_error, wb_valid, rs1_data, rs2_data);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1;  // stray ack in IDLE must be ignored
    mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wb_valid || mem_req) seen_wb = 1;
    end
    mem_ack = 1'b0;
    compared++;
    if (seen_wb || rs2_data !== 32'd0) begin
      mismatched++;
      $display("FAIL rmid_after: activity=%0d rs2=%h after reset release, required 0/0", seen_wb, rs2_data);
    end
    $display("reset mid-MEM done");
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_result = '0;
    in_reg_write_enable = 1'b0;
    in_mem_write_enable = 1'b0;
    in_mem_read_enable = 1'b0;
    in_register = '0;
    in_mem_address = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    rs1_addr = '0;
    rs2_addr = '0;

    test_reset;
    test_alu;
    test_store;
    test_load;
    test_reg0;
    test_timeout;
    test_back_to_back;
    test_reset_mid;

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_leftover: %0d expected writebacks never seen, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_writeback.md
# mem_writeback

Memory-access and writeback stage that consumes the decode/execute stage's outputs: result, reg_write_enable, mem_write_enable, register and mem_address. It performs data-memory loads and stores over a req/ack handshake and owns the 32x32 architectural register file. It exposes two combinational read ports back to decode, and a valid/ready handshake that stalls the upstream stage while a memory access is outstanding.

## Interface
- TIMEOUT, 15, max cycles in MEM waiting for mem_ack before abort (1..15)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  stage can accept; high only in IDLE
- in_result  input  32  ALU result / store data
- in_reg_write_enable  input  1  write in_register at writeback
- in_mem_write_enable  input  1  store in_result to in_mem_address
- in_mem_read_enable  input  1  load from in_mem_address into in_register
- in_register  input  5  destination register
- in_mem_address  input  32  data-memory byte address
- mem_req  output  1  memory request, held until ack or timeout
- mem_we  output  1  1 = store, 0 = load; valid while mem_req
- mem_addr  output  32  captured address
- mem_wdata  output  32  captured in_result
- mem_ack  input  1  one-cycle completion; mem_rdata valid same cycle
- mem_rdata  input  32  load data
- rs1_addr, rs2_addr  input  5 each  register read addresses
- rs1_data, rs2_data  output  32 each  combinational read data with bypass
- wb_valid  output  1  one-cycle pulse when a register is written
- wb_register  output  5  register written (valid with wb_valid)
- wb_data  output  32  data written (valid with wb_valid)
- bus_error  output  1  one-cycle pulse on memory timeout

## Operation
- States: IDLE, MEM, WB.
- IDLE accepts when in_valid && in_ready. All inputs are captured into internal registers.
  - Any mem enable set: next state MEM.
  - Else in_reg_write_enable set: next state WB.
  - Else: no-op, stay IDLE.
- Both mem enables set: treated as a store. The load is ignored, as is in_reg_write_enable.
- A load writes mem_rdata to in_register regardless of in_reg_write_enable.
- A store never writes the register file, even if in_reg_write_enable is set.
- MEM:
  - mem_req=1; mem_we, mem_addr and mem_wdata are held stable.
  - 4-bit wait counter clears on entry and increments each cycle without ack.
  - mem_ack on a load: capture mem_rdata, go to WB.
  - mem_ack on a store: go to IDLE.
  - Counter == TIMEOUT-1 with no ack: drop mem_req, pulse bus_error, go to IDLE, no register write.
- WB:
  - Write wb_data to register file entry wb_register at the end of the cycle.
  - wb_valid=1 for that cycle. Next state IDLE.
- Register 0 is hardwired zero:
  - Writes to it are discarded, but wb_valid still pulses with wb_register=0.
  - Reads of it return 0.
- Read ports: rs*_data = regfile[rs*_addr].
  - Bypass: in WB with rs*_addr == wb_register != 0, return wb_data instead.
- Reset values:
  - State IDLE; in_ready=1.
  - mem_req, mem_we, wb_valid, bus_error = 0.
  - mem_addr, mem_wdata, wb_register, wb_data = 0.
  - All 32 registers = 0.
- Reset mid-operation aborts immediately: mem_req drops asynchronously and no writeback occurs.
- mem_ack while not in MEM is ignored.

## Timing
- Accept at edge E0, then the registered outputs follow.
- ALU-only op:
  - WB during cycle E0..E1; wb_valid high that cycle.
  - Register file updated at E1.
  - in_ready low for exactly 1 cycle.
- Store:
  - mem_req high from E0 until the edge at which mem_ack is sampled.
  - Zero-wait ack (ack in first MEM cycle): mem_req high 1 cycle, in_ready low 1 cycle.
- Load with zero-wait ack:
  - MEM for 1 cycle, then WB for 1 cycle.
  - in_ready low 2 cycles; register updated 2 edges after accept.
- Each added wait cycle adds one cycle of latency.
- Timeout: mem_req high exactly TIMEOUT cycles; bus_error pulses the cycle after the last MEM cycle (with state IDLE).
- Throughput:
  - Back-to-back ALU ops: one accepted every 2 cycles.
  - A new op may be accepted in the cycle immediately after WB or store completion.
- rs*_data is combinational from rs*_addr, the register file and the WB-state bypass. There are no registered read paths.

## Test plan
- ALU op (in_result=0x0000_00A5, regwe=1, register=7): wb_valid pulses one cycle later, wb_register=7, wb_data=0xA5. rs1_addr=7 reads 0xA5 during WB (bypass) and after.
- Store (addr=0x100, data=0xDEADBEEF), mem_ack after 3 wait cycles: mem_req high 4 cycles with mem_we=1, mem_addr/wdata stable; no wb_valid; in_ready returns high the next cycle.
- Load (addr=0x200, register=12), ack with mem_rdata=0x1234_5678 in the first MEM cycle: reg 12 = 0x12345678 two edges after accept; wb_valid pulses once.
- Writes to register 0 (ALU op result=0xFFFF_FFFF, register=0): wb_valid pulses; rs2_addr=0 still reads 0.
- Load with no ack (TIMEOUT=15): mem_req high exactly 15 cycles, then one bus_error pulse; register unchanged; the next op is accepted normally.
- Assert reset mid-MEM after 2 cycles: mem_req drops immediately; all outputs and registers reset; no wb_valid after reset release.
